// File: rtl/nco_phase_gen_pkg.sv
// Shared types and default widths for the NCO phase generator slice.
package nco_phase_gen_pkg;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } nco_state_t;

endpackage

// File: rtl/nco_phase_gen_if.sv
// Configuration, control and address-stream signals of the NCO phase generator.
interface nco_phase_gen_if
  import nco_phase_gen_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_ftw;
  logic [ADDR_W-1:0]  cfg_poff;
  logic [CNT_W-1:0]   cfg_count;
  logic               start;
  logic               stop;
  logic [ADDR_W-1:0]  address;
  logic               addr_valid;
  logic               addr_ready;
  logic               rom_valid;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_ftw, cfg_poff, cfg_count, start, stop, addr_ready,
    input  cfg_ready, address, addr_valid, rom_valid, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_ftw, cfg_poff, cfg_count, start, stop, addr_ready,
    output cfg_ready, address, addr_valid, rom_valid, busy, done
  );

endinterface

// File: rtl/nco_top.sv
// NCO assembly: phase generator addressing the registered sine ROM.
module nco_top
  import nco_phase_gen_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DATA_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  nco_phase_gen_if.slave           bus,
  output logic signed [DATA_W-1:0] sine
);

  nco_phase_gen #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) u_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sine_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .clock   (clock),
    .address (bus.address),
    .sine    (sine)
  );

endmodule

// File: rtl/sine_rom.sv
// Registered sine lookup; a parabolic half-wave approximation stands in for a table.
module sine_rom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clock,
  input  logic [ADDR_W-1:0]        address,
  output logic signed [DATA_W-1:0] sine
);

  localparam int HALF  = ADDR_W - 1;
  localparam int PW    = 2 * ADDR_W + DATA_W;
  localparam int SHIFT = 2 * HALF - 2;
  localparam int AMP   = (2 ** (DATA_W - 1)) - 1;

  // 4*t*(N-t)/N^2 peaks at 1 mid half-period; the MSB selects the negative half.
  function automatic logic signed [DATA_W-1:0] sine_approx(input logic [ADDR_W-1:0] a);
    logic [HALF-1:0]          t;
    logic [HALF:0]            n_minus_t;
    logic [PW-1:0]            prod;
    logic signed [DATA_W-1:0] mag;
    t         = a[HALF-1:0];
    n_minus_t = {1'b1, {HALF{1'b0}}} - {1'b0, t};
    prod      = PW'(t) * PW'(n_minus_t) * PW'(AMP);
    mag       = DATA_W'(prod >> SHIFT);
    return a[ADDR_W-1] ? -mag : mag;
  endfunction

  always_ff @(posedge clock) begin
    sine <= sine_approx(address);
  end

endmodule

// File: rtl/nco_phase_gen.sv
// Burst-controlled phase accumulator producing registered sine ROM addresses.
module nco_phase_gen
  import nco_phase_gen_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic            clock,
  input  logic            reset_n,
  nco_phase_gen_if.slave  bus
);

  nco_state_t         state, state_nxt;
  logic [PHASE_W-1:0] ftw_q;
  logic [ADDR_W-1:0]  poff_q;
  logic [CNT_W-1:0]   count_q;
  logic [PHASE_W-1:0] phase_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [ADDR_W-1:0]  address_p0;
  logic               vld_p1;

  logic               cfg_accept;
  logic               launch;
  logic               beat;
  logic               last_beat;
  logic [ADDR_W-1:0]  poff_eff;
  logic [CNT_W-1:0]   count_eff;
  logic [PHASE_W-1:0] phase_nxt;

  function automatic logic [ADDR_W-1:0] phase_to_addr(
    input logic [PHASE_W-1:0] phase,
    input logic [ADDR_W-1:0]  poff
  );
    return phase[PHASE_W-1 -: ADDR_W] + poff;
  endfunction

  always_comb begin
    cfg_accept = bus.cfg_valid && (state == ST_IDLE);
    launch     = bus.start && (state == ST_IDLE);
    beat       = (state == ST_RUN) && bus.addr_ready;
    last_beat  = beat && (count_q != '0) && (remaining_q == CNT_W'(1));
    // A configuration accepted together with start must take effect for that burst.
    poff_eff   = cfg_accept ? bus.cfg_poff  : poff_q;
    count_eff  = cfg_accept ? bus.cfg_count : count_q;
    phase_nxt  = phase_q + ftw_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (launch) state_nxt = ST_RUN;
      ST_RUN:   if (bus.stop || last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ftw_q       <= '0;
      poff_q      <= '0;
      count_q     <= '0;
      phase_q     <= '0;
      remaining_q <= '0;
      address_p0  <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= beat;
      if (cfg_accept) begin
        ftw_q   <= bus.cfg_ftw;
        poff_q  <= bus.cfg_poff;
        count_q <= bus.cfg_count;
      end
      if (launch) begin
        phase_q     <= '0;
        remaining_q <= count_eff;
        address_p0  <= phase_to_addr('0, poff_eff);
      end else if (beat) begin
        phase_q    <= phase_nxt;
        address_p0 <= phase_to_addr(phase_nxt, poff_q);
        if (count_q != '0) remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

  // p1: ROM output stage, one cycle behind the accepted address
  assign bus.rom_valid  = vld_p1;
  assign bus.address    = address_p0;
  assign bus.addr_valid = (state == ST_RUN);
  assign bus.cfg_ready  = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DRAIN);

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: per-cycle vector table plus multi-cycle corner sequences.
module tb_nco_phase_gen;

  localparam logic [31:0] FTW1 = 32'h0100_0000;
  localparam logic [31:0] FTWQ = 32'h4000_0000;

  logic clock = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  logic signed [15:0] sine;

  nco_phase_gen_if #(.PHASE_W(32), .ADDR_W(8), .CNT_W(16)) bus ();
  nco_phase_gen_if #(.PHASE_W(32), .ADDR_W(8), .CNT_W(16)) bus2 ();

  nco_phase_gen #(.PHASE_W(32), .ADDR_W(8), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus2.cfg_valid  = bus.cfg_valid;
  assign bus2.cfg_ftw    = bus.cfg_ftw;
  assign bus2.cfg_poff   = bus.cfg_poff;
  assign bus2.cfg_count  = bus.cfg_count;
  assign bus2.start      = bus.start;
  assign bus2.stop       = bus.stop;
  assign bus2.addr_ready = bus.addr_ready;

  nco_top #(.PHASE_W(32), .ADDR_W(8), .CNT_W(16), .DATA_W(16)) u_top (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus2),
    .sine    (sine)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        cv;
    logic [31:0] ftw;
    logic [7:0]  poff;
    logic [15:0] cnt;
    logic        st;
    logic        sp;
    logic        rdy;
    logic [7:0]  e_addr;
    logic [4:0]  e_flags;   // {addr_valid, rom_valid, busy, done, cfg_ready}
    logic        chk_sine;
    logic [15:0] e_sine;
  } vec_t;

  vec_t tv[$];

  task automatic add(input string n, input logic cv, input logic [31:0] ftw,
                     input logic [7:0] poff, input logic [15:0] cnt, input logic st,
                     input logic sp, input logic rdy, input logic [7:0] ea,
                     input logic [4:0] ef, input logic cs, input logic [15:0] es);
    vec_t v;
    v.name = n; v.cv = cv; v.ftw = ftw; v.poff = poff; v.cnt = cnt; v.st = st;
    v.sp = sp; v.rdy = rdy; v.e_addr = ea; v.e_flags = ef; v.chk_sine = cs; v.e_sine = es;
    tv.push_back(v);
  endtask

  task automatic set_in(input logic cv, input logic [31:0] ftw, input logic [7:0] poff,
                        input logic [15:0] cnt, input logic st, input logic sp, input logic rdy);
    bus.cfg_valid  = cv;
    bus.cfg_ftw    = ftw;
    bus.cfg_poff   = poff;
    bus.cfg_count  = cnt;
    bus.start      = st;
    bus.stop       = sp;
    bus.addr_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [12:0] obs();
    return {bus.address, bus.addr_valid, bus.rom_valid, bus.busy, bus.done, bus.cfg_ready};
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic run_cont(input string tag, input logic rdy_at_stop, input int exp_rv);
    int rv_n = 0;
    int done_n = 0;
    set_in(1'b1, FTW1, 8'h00, 16'd0, 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      rv_n += int'(bus.rom_valid);
      done_n += int'(bus.done);
    end
    check({tag, "_still_busy"}, {31'd0, bus.busy}, 32'd1);
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b1, rdy_at_stop);
    tick();
    rv_n += int'(bus.rom_valid);
    done_n += int'(bus.done);
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      rv_n += int'(bus.rom_valid);
      done_n += int'(bus.done);
    end
    check({tag, "_rom_valid_count"}, rv_n, exp_rv);
    check({tag, "_done_count"}, done_n, 32'd1);
    check({tag, "_idle"}, {19'd0, obs()} & 32'h1F, 32'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic burst: 4 beats, addresses 0..3
    add("basic0", 1, FTW1, 8'h00, 16'd4, 1, 0, 1, 8'h00, 5'b10100, 0, 16'h0);
    add("basic1", 0, '0, '0, '0, 0, 0, 1, 8'h01, 5'b11100, 0, 16'h0);
    add("basic2", 0, '0, '0, '0, 0, 0, 1, 8'h02, 5'b11100, 0, 16'h0);
    add("basic3", 0, '0, '0, '0, 0, 0, 1, 8'h03, 5'b11100, 0, 16'h0);
    add("basic4", 0, '0, '0, '0, 0, 0, 1, 8'h04, 5'b01110, 0, 16'h0);
    add("basic5", 0, '0, '0, '0, 0, 0, 1, 8'h04, 5'b00001, 0, 16'h0);
    // backpressure: three stalled cycles after the first beat
    add("bp0", 1, FTW1, 8'h10, 16'd4, 1, 0, 1, 8'h10, 5'b10100, 0, 16'h0);
    add("bp1", 0, '0, '0, '0, 0, 0, 1, 8'h11, 5'b11100, 0, 16'h0);
    add("bp2", 0, '0, '0, '0, 0, 0, 0, 8'h11, 5'b10100, 0, 16'h0);
    add("bp3", 0, '0, '0, '0, 0, 0, 0, 8'h11, 5'b10100, 0, 16'h0);
    add("bp4", 0, '0, '0, '0, 0, 0, 0, 8'h11, 5'b10100, 0, 16'h0);
    add("bp5", 0, '0, '0, '0, 0, 0, 1, 8'h12, 5'b11100, 0, 16'h0);
    add("bp6", 0, '0, '0, '0, 0, 0, 1, 8'h13, 5'b11100, 0, 16'h0);
    add("bp7", 0, '0, '0, '0, 0, 0, 1, 8'h14, 5'b01110, 0, 16'h0);
    add("bp8", 0, '0, '0, '0, 0, 0, 1, 8'h14, 5'b00001, 0, 16'h0);
    // wrap: quarter-turn steps with offset C0, ROM output checked at each rom_valid
    add("wrap0", 1, FTWQ, 8'hC0, 16'd5, 1, 0, 1, 8'hC0, 5'b10100, 0, 16'h0);
    add("wrap1", 0, '0, '0, '0, 0, 0, 1, 8'h00, 5'b11100, 1, 16'h8001);
    add("wrap2", 0, '0, '0, '0, 0, 0, 1, 8'h40, 5'b11100, 1, 16'h0000);
    add("wrap3", 0, '0, '0, '0, 0, 0, 1, 8'h80, 5'b11100, 1, 16'h7FFF);
    add("wrap4", 0, '0, '0, '0, 0, 0, 1, 8'hC0, 5'b11100, 1, 16'h0000);
    add("wrap5", 0, '0, '0, '0, 0, 0, 1, 8'h00, 5'b01110, 1, 16'h8001);
    add("wrap6", 0, '0, '0, '0, 0, 0, 1, 8'h00, 5'b00001, 0, 16'h0);

    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {19'd0, obs()}, {19'd0, 8'h00, 5'b00001});
    reset_n = 1'b1;
    tick();

    foreach (tv[i]) begin
      set_in(tv[i].cv, tv[i].ftw, tv[i].poff, tv[i].cnt, tv[i].st, tv[i].sp, tv[i].rdy);
      tick();
      check(tv[i].name, {19'd0, obs()}, {19'd0, tv[i].e_addr, tv[i].e_flags});
      if (tv[i].chk_sine)
        check({tv[i].name, "_sine"}, {16'd0, sine}, {16'd0, tv[i].e_sine});
    end

    // continuous mode, stopped without and with a coincident beat
    run_cont("cont_nobeat", 1'b0, 3);
    run_cont("cont_beat", 1'b1, 4);

    // configuration offered while running must be ignored
    set_in(1'b1, FTW1, 8'h00, 16'd3, 1'b1, 1'b0, 1'b1);
    tick();
    check("cfgblk_start_addr", {24'd0, bus.address}, 32'h00);
    set_in(1'b1, 32'h1000_0000, 8'h55, 16'd9, 1'b1, 1'b0, 1'b1);
    #1;
    check("cfgblk_ready_low", {31'd0, bus.cfg_ready}, 32'd0);
    tick();
    check("cfgblk_addr1", {24'd0, bus.address}, 32'h01);
    tick();
    check("cfgblk_addr2", {24'd0, bus.address}, 32'h02);
    tick();
    check("cfgblk_drain", {19'd0, obs()}, {19'd0, 8'h03, 5'b01110});
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    // simultaneous cfg and start: the new word drives this burst
    set_in(1'b1, 32'h2000_0000, 8'h03, 16'd2, 1'b1, 1'b0, 1'b1);
    tick();
    check("cfgnew_start_addr", {24'd0, bus.address}, 32'h03);
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("cfgnew_addr1", {24'd0, bus.address}, 32'h23);
    tick();
    check("cfgnew_drain", {19'd0, obs()}, {19'd0, 8'h43, 5'b01110});
    tick();

    // reset asserted mid-burst
    set_in(1'b1, FTW1, 8'h20, 16'd10, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("rstmid_running", {19'd0, obs()}, {19'd0, 8'h22, 5'b11100});
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_outputs", {19'd0, obs()}, {19'd0, 8'h00, 5'b00001});
    tick();
    tick();
    check("rstmid_held", {19'd0, obs()}, {19'd0, 8'h00, 5'b00001});
    reset_n = 1'b1;
    tick();
    check("rstmid_after", {19'd0, obs()}, {19'd0, 8'h00, 5'b00001});
    // registers were cleared: a start without cfg runs continuously from poff 0 with ftw 0
    set_in(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("rstmid_cleared_regs", {19'd0, obs()}, {19'd0, 8'h00, 5'b11100});
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rstmid_final_idle", {19'd0, obs()} & 32'h1F, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nco_phase_gen.md
NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 Parameter PHASE_W, default 32: phase accumulator width in bits.
REQ-002 Parameter ADDR_W, default 8: ROM address width in bits; the address is the top ADDR_W bits of the phase.
REQ-003 Parameter CNT_W, default 16: burst counter width in bits.
REQ-004 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port cfg_valid, input, 1: configuration word offered.
REQ-007 Port cfg_ready, output, 1: configuration can be accepted.
REQ-008 Port cfg_ftw, input, PHASE_W: frequency tuning word (phase increment per beat).
REQ-009 Port cfg_poff, input, ADDR_W: phase offset added to the address.
REQ-010 Port cfg_count, input, CNT_W: beats per burst; 0 means continuous.
REQ-011 Port start, input, 1: begin a burst; level is sampled each cycle.
REQ-012 Port stop, input, 1: terminate a burst early.
REQ-013 Port address, output, ADDR_W: sine ROM address.
REQ-014 Port addr_valid, output, 1: address is valid.
REQ-015 Port addr_ready, input, 1: downstream accepts the address; a beat is addr_valid && addr_ready.
REQ-016 Port rom_valid, output, 1: ROM sine output is valid this cycle.
REQ-017 Port busy, output, 1: high while the FSM is not IDLE.
REQ-018 Port done, output, 1: one-cycle burst-complete pulse.

Function
REQ-019 The block SHALL be an FSM with states IDLE, RUN and DRAIN.
REQ-020 cfg_ready SHALL be 1 only in IDLE; cfg_valid && cfg_ready SHALL register ftw, poff and count.
REQ-021 start in IDLE SHALL zero the phase and load remaining = count, then go to RUN; if cfg is accepted in the same cycle, the new cfg values SHALL be used.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 addr_valid SHALL equal (state == RUN).
REQ-024 address SHALL equal phase[PHASE_W-1 -: ADDR_W] + poff, modulo 2^ADDR_W, and SHALL be a registered output.
REQ-025 On a beat, the phase SHALL advance by ftw modulo 2^PHASE_W.
REQ-026 Without a beat, address and phase SHALL hold stable.
REQ-027 When count != 0, each beat SHALL decrement remaining; the beat taking remaining to 0 SHALL move the FSM to DRAIN.
REQ-028 When count == 0, RUN SHALL continue until stop.
REQ-029 stop in RUN SHALL move the FSM to DRAIN next cycle; a beat in the same cycle as stop SHALL still count.
REQ-030 rom_valid SHALL be the beat signal registered once, matching the ROM's 1-cycle registered latency.
REQ-031 DRAIN SHALL last exactly 1 cycle, assert done there, then return to IDLE.

Reset
REQ-032 While reset_n is low, the outputs SHALL be: state IDLE, address 0, addr_valid 0, rom_valid 0, busy 0, done 0, cfg_ready 1.
REQ-033 While reset_n is low, the ftw, poff, count, phase and remaining registers SHALL all be 0.
REQ-034 Reset asserted mid-burst SHALL abort immediately with no done pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the default PHASE_W, ADDR_W and CNT_W constants.
REQ-036 The block SHALL have no sub-module; nco_top SHALL instantiate nco_phase_gen feeding sine_rom.

Verification
REQ-037 Scenario basic burst: ftw=0x01000000, poff=0, count=4, addr_ready=1 -> addresses 0,1,2,3 on consecutive cycles; rom_valid lags each by 1 cycle; done coincides with the last rom_valid.
REQ-038 Scenario wrap: ftw=0x40000000, poff=0xC0, count=5 -> addresses C0,00,40,80,C0.
REQ-039 Scenario backpressure: addr_ready low for 3 cycles mid-burst -> address held; no rom_valid during the stall; 4 rom_valid total for count=4.
REQ-040 Scenario continuous: count=0, stop asserted after 3 beats -> exactly 3 (or 4 if a beat fires with stop) rom_valid, then done.
REQ-041 Scenario config blocked: cfg_valid in RUN -> cfg_ready=0 and registers unchanged; simultaneous cfg+start in IDLE -> burst uses the new ftw.
REQ-042 Scenario reset mid-burst: reset_n low in RUN -> all outputs 0 immediately, cfg_ready=1, no done pulse.
